// File: rtl/demux_led_pkg.sv
// Shared constants and types for the 1-to-4 LED demultiplexer demo.
// Switch indices name which debounced button drives which action.
package demux_led_pkg;

  localparam int LED_COUNT              = 4;
  localparam int SEL_W                  = 2;
  localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;

  localparam int SW_DATA  = 0;
  localparam int SW_SEL   = 1;
  localparam int SW_CLEAR = 2;
  localparam int SW_MODE  = 3;

  typedef enum logic {
    MODE_TRANSPARENT = 1'b0,
    MODE_LATCHED     = 1'b1
  } mode_e;

endpackage

// File: rtl/switch_debounce_filter.sv
// Debounces one raw push-button and produces its stable level and a
// one-cycle pulse on each accepted rising edge.
module switch_debounce_filter #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press
);

  localparam int CNT_W = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             stable_d, stable_q;
  logic             prev_q;

  // Any sample equal to the accepted level restarts the stability count.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (i_Switch != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = i_Switch;
        cnt_d    = '0;
      end else begin
        stable_d = stable_q;
        cnt_d    = cnt_q + CNT_W'(1);
      end
    end else begin
      stable_d = stable_q;
      cnt_d    = '0;
    end
  end

  // Counter, accepted level and edge history registers.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= stable_q;
    end
  end

  assign o_Switch = stable_q;
  assign o_Press  = stable_q & ~prev_q;

endmodule

// File: rtl/demux_1_to_4_led.sv
// Routes a button-controlled data bit to one of four LEDs, either
// transparently (only the selected LED lit) or latched (LEDs hold their last write).
module demux_1_to_4_led
  import demux_led_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  input  logic i_Switch_3,
  input  logic i_Switch_4,
  output logic o_LED_1,
  output logic o_LED_2,
  output logic o_LED_3,
  output logic o_LED_4
);

  logic [LED_COUNT-1:0] raw_s;
  logic [LED_COUNT-1:0] press_s;
  logic [LED_COUNT-1:0] level_unused_s;

  logic                 data_d, data_q;
  logic [SEL_W-1:0]     sel_d, sel_q;
  mode_e                mode_d, mode_q;
  logic [LED_COUNT-1:0] led_d, led_q;

  assign raw_s = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  for (genvar g = 0; g < LED_COUNT; g++) begin : g_sw
    switch_debounce_filter #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_filter (
      .i_Clk    (i_Clk),
      .i_Reset  (i_Reset),
      .i_Switch (raw_s[g]),
      .o_Switch (level_unused_s[g]),
      .o_Press  (press_s[g])
    );
  end

  // Next-state control; LEDs are written from the new data/select/mode.
  always_comb begin
    data_d = data_q;
    sel_d  = sel_q;
    mode_d = mode_q;
    led_d  = led_q;

    if (press_s[SW_CLEAR]) begin
      data_d = 1'b0;
    end else if (press_s[SW_DATA]) begin
      data_d = ~data_q;
    end else begin
      data_d = data_q;
    end

    if (press_s[SW_SEL]) begin
      sel_d = sel_q + SEL_W'(1);
    end else begin
      sel_d = sel_q;
    end

    if (press_s[SW_MODE]) begin
      mode_d = (mode_q == MODE_TRANSPARENT) ? MODE_LATCHED : MODE_TRANSPARENT;
    end else begin
      mode_d = mode_q;
    end

    if (press_s[SW_CLEAR]) begin
      led_d = '0;
    end else if (mode_d == MODE_TRANSPARENT) begin
      led_d        = '0;
      led_d[sel_d] = data_d;
    end else begin
      led_d        = led_q;
      led_d[sel_d] = data_d;
    end
  end

  // Control and LED destination registers.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      data_q <= 1'b0;
      sel_q  <= '0;
      mode_q <= MODE_TRANSPARENT;
      led_q  <= '0;
    end else begin
      data_q <= data_d;
      sel_q  <= sel_d;
      mode_q <= mode_d;
      led_q  <= led_d;
    end
  end

  assign o_LED_1 = led_q[0];
  assign o_LED_2 = led_q[1];
  assign o_LED_3 = led_q[2];
  assign o_LED_4 = led_q[3];

endmodule

// File: tb/tb_demux_1_to_4_led.sv
// Scoreboarded bench: a cycle-level behavioural model predicts the LED vector
// after every clock edge; a monitor compares it against the DUT each cycle.
module tb_demux_1_to_4_led;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = 4'b0000;
  logic       led1, led2, led3, led4;
  logic [3:0] leds;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] exp_q[$];

  // model state
  int   run_m[4];
  bit   stable_m[4];
  bit   rose_m[4];
  bit   data_m;
  int   sel_m;
  bit   latched_m;
  bit   led_m[4];

  demux_1_to_4_led #(.DEBOUNCE_LIMIT(LIMIT)) dut (
    .i_Clk      (clk),
    .i_Reset    (rst),
    .i_Switch_1 (sw[0]),
    .i_Switch_2 (sw[1]),
    .i_Switch_3 (sw[2]),
    .i_Switch_4 (sw[3]),
    .o_LED_1    (led1),
    .o_LED_2    (led2),
    .o_LED_3    (led3),
    .o_LED_4    (led4)
  );

  assign leds = {led4, led3, led2, led1};

  initial forever #5 clk = ~clk;

  // Reference model: a level is accepted after LIMIT consecutive samples that
  // disagree with it; an accepted rise acts on the LEDs one edge later.
  initial forever begin
    logic [3:0] e;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        run_m[k] = 0; stable_m[k] = 0; rose_m[k] = 0; led_m[k] = 0;
      end
      data_m = 0; sel_m = 0; latched_m = 0;
    end else begin
      if (rose_m[2]) data_m = 0;
      else if (rose_m[0]) data_m = !data_m;
      if (rose_m[1]) sel_m = (sel_m + 1) % 4;
      if (rose_m[3]) latched_m = !latched_m;
      for (int i = 0; i < 4; i++) begin
        if (rose_m[2]) led_m[i] = 0;
        else if (i == sel_m) led_m[i] = data_m;
        else if (!latched_m) led_m[i] = 0;
      end
      for (int k = 0; k < 4; k++) begin
        rose_m[k] = 0;
        if (sw[k] != stable_m[k]) begin
          run_m[k]++;
          if (run_m[k] == LIMIT) begin
            stable_m[k] = sw[k];
            run_m[k]    = 0;
            rose_m[k]   = sw[k];
          end
        end else begin
          run_m[k] = 0;
        end
      end
    end
    for (int i = 0; i < 4; i++) e[i] = led_m[i];
    exp_q.push_back(e);
  end

  // Monitor: one expected vector per edge, checked mid-cycle.
  initial forever begin
    logic [3:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (leds !== e) begin
        n_bad++;
        $display("FAIL led_cycle: got %b expected %b at %0t", leds, e, $time);
      end
    end
  end

  task automatic tick(input logic r, input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      rst = r;
      sw  = s;
    end
  endtask

  task automatic press(input logic [3:0] m);
    tick(1'b0, m, LIMIT + 2);
    tick(1'b0, 4'b0000, LIMIT + 3);
  endtask

  task automatic expect_leds(input logic [3:0] want, input string name);
    @(negedge clk);
    n_cmp++;
    if (leds !== want) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, leds, want);
    end
  endtask

  initial begin
    tick(1'b1, 4'b0000, 3);
    tick(1'b0, 4'b0000, 20);
    expect_leds(4'b0000, "reset_idle");

    // reset mid-count discards partial debounce
    tick(1'b0, 4'b0001, 2);
    tick(1'b1, 4'b0001, 1);
    tick(1'b0, 4'b0000, 10);
    expect_leds(4'b0000, "reset_mid_count");

    tick(1'b0, 4'b0001, 8);
    expect_leds(4'b0001, "sw1_hold");
    tick(1'b0, 4'b0000, 8);

    // bounce 1,0,1 then hold: toggles data back to 0
    tick(1'b0, 4'b0001, 1);
    tick(1'b0, 4'b0000, 1);
    tick(1'b0, 4'b0001, 8);
    tick(1'b0, 4'b0000, 8);
    expect_leds(4'b0000, "sw1_bounce");

    press(4'b0001);
    expect_leds(4'b0001, "walk_0");
    press(4'b0010);
    expect_leds(4'b0010, "walk_1");
    press(4'b0010);
    expect_leds(4'b0100, "walk_2");
    press(4'b0010);
    expect_leds(4'b1000, "walk_3");
    press(4'b0010);
    expect_leds(4'b0001, "walk_wrap");

    press(4'b1000);
    press(4'b0010);
    press(4'b0001);
    press(4'b0010);
    expect_leds(4'b0001, "latched_hold");
    press(4'b1000);
    expect_leds(4'b0000, "back_transparent");

    press(4'b0010);
    press(4'b0010);
    press(4'b0011);
    expect_leds(4'b0010, "sw1_sw2_together");

    press(4'b1000);
    press(4'b0001);
    press(4'b0010);
    press(4'b0010);
    press(4'b0010);
    press(4'b0001);
    press(4'b0010);
    expect_leds(4'b0011, "latched_pattern");
    press(4'b0101);
    expect_leds(4'b0000, "clear_beats_toggle");

    press(4'b1000);
    tick(1'b1, 4'b0001, 3);
    tick(1'b0, 4'b0001, 12);
    expect_leds(4'b0001, "held_through_reset");
    tick(1'b0, 4'b0000, 8);

    // random bouncy stimulus with occasional resets
    for (int i = 0; i < 120; i++) begin
      logic [3:0] s;
      logic       r;
      s = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0;
      tick(r, s, $urandom_range(1, 7));
    end
    tick(1'b0, 4'b0000, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
